carfield_boot_ctrl: RTL and testbench

Boot sequencer between the SoC reset tree and the host CVA6 core. It holds the core in reset after system reset and supplies the 64-bit-aligned boot address, defaulting to the Carfield boot address `0x0000_0000_0100_0000`. It releases the core either autonomously or on a GO command written over the register interface, e.g. by JTAG or serial link preload. It sits on the Cheshire register bus as a regbus slave, directly downstream of the configuration defined in `carfield_pkg`.

---
 rtl/carfield_pkg.sv | 29 ++
 rtl/carfield_boot_ctrl.sv | 150 +++++++++++++++
 tb/tb_carfield_boot_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/carfield_pkg.sv
// Carfield SoC-level constants shared by the boot controller.
package carfield_pkg;

    // Reset boot address of the host core.
    localparam logic [63:0] carfield_boot_addr = 64'h0000_0000_0100_0000;

    // Boot controller register byte offsets.
    localparam logic [3:0] BootLoOffs = 4'h0;
    localparam logic [3:0] BootHiOffs = 4'h4;
    localparam logic [3:0] CtrlOffs   = 4'h8;
    localparam logic [3:0] StatusOffs = 4'hC;

    // Boot sequencer states; encodings are visible in STATUS[1:0].
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        WAIT    = 2'd1,
        RUNNING = 2'd2
    } boot_state_e;

    // Flattened register-bus request as seen by the boot controller.
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } boot_reg_req_t;

endpackage

// File: rtl/carfield_boot_ctrl.sv
// Boot sequencer: holds the host core in reset, owns the boot address
// register and releases the core autonomously or on a GO register write.
module carfield_boot_ctrl
    import carfield_pkg::*;
#(
    parameter int unsigned AddrWidth       = 48,
    parameter logic [63:0] DefaultBootAddr = carfield_boot_addr,
    parameter int unsigned RstHoldCycles   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           bootmode_i,
    input  logic                 reg_valid_i,
    input  logic                 reg_write_i,
    input  logic [3:0]           reg_addr_i,
    input  logic [31:0]          reg_wdata_i,
    input  logic [3:0]           reg_wstrb_i,
    output logic                 reg_ready_o,
    output logic [31:0]          reg_rdata_o,
    output logic                 reg_error_o,
    output logic [AddrWidth-1:0] boot_addr_o,
    output logic                 core_rst_no,
    output logic                 core_released_o
);

    // A width of 1 keeps the counter legal when the hold is a single cycle.
    localparam int unsigned     CntW    = (RstHoldCycles > 1) ? $clog2(RstHoldCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(RstHoldCycles - 1);

    boot_state_e          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [1:0]           bootmode_q, bootmode_d;
    logic                 go_pending_q, go_pending_d;
    logic [AddrWidth-1:0] boot_q, boot_d;
    logic                 core_rst_q;

    boot_reg_req_t req;
    logic          acc_err;
    logic          lo_we, hi_we, go_wr;
    logic [63:0]   boot_full;

    assign req = '{valid: reg_valid_i, write: reg_write_i, addr: reg_addr_i,
                   wdata: reg_wdata_i, wstrb: reg_wstrb_i};

    // Zero-extended view so BOOT_HI reads bits above AddrWidth as 0.
    assign boot_full = 64'(boot_q);

    // Access decode: errors suppress every side effect of the access.
    always_comb begin
        acc_err = 1'b0;
        if (req.valid) begin
            if (req.addr[1:0] != 2'b00) begin
                acc_err = 1'b1;
            end else if (req.write && req.addr == StatusOffs) begin
                acc_err = 1'b1;
            end else if (req.write && state_q == RUNNING &&
                         (req.addr == BootLoOffs || req.addr == BootHiOffs)) begin
                acc_err = 1'b1;
            end
        end
        lo_we = req.valid && req.write && !acc_err && req.addr == BootLoOffs;
        hi_we = req.valid && req.write && !acc_err && req.addr == BootHiOffs;
        go_wr = req.valid && req.write && !acc_err && req.addr == CtrlOffs &&
                req.wstrb[0] && req.wdata[0];
    end

    // Read mux; writes and errored accesses return zero.
    always_comb begin
        reg_rdata_o = 32'h0;
        if (req.valid && !req.write && !acc_err) begin
            case (req.addr)
                BootLoOffs: reg_rdata_o = boot_full[31:0];
                BootHiOffs: reg_rdata_o = boot_full[63:32];
                StatusOffs: reg_rdata_o = {27'h0, go_pending_q, bootmode_q, state_q};
                default:    reg_rdata_o = 32'h0;
            endcase
        end
    end

    assign reg_ready_o = reg_valid_i;
    assign reg_error_o = acc_err;

    // Per-bit byte-strobed update; bits above AddrWidth simply do not exist.
    for (genvar i = 0; i < AddrWidth; i++) begin : g_boot_bit
        if (i < 32) begin : g_lo
            assign boot_d[i] = (lo_we && req.wstrb[i/8]) ? req.wdata[i] : boot_q[i];
        end else begin : g_hi
            assign boot_d[i] = (hi_we && req.wstrb[(i-32)/8]) ? req.wdata[i-32] : boot_q[i];
        end
    end

    // Sequencer next state; a GO in the expiry cycle counts as pending.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bootmode_d   = bootmode_q;
        go_pending_d = go_pending_q;
        case (state_q)
            HOLD: begin
                go_pending_d = go_pending_q | go_wr;
                if (cnt_q == CntLast) begin
                    bootmode_d   = bootmode_i;
                    go_pending_d = 1'b0;
                    if (bootmode_i == 2'd0 || go_pending_q || go_wr) begin
                        state_d = RUNNING;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (go_wr) state_d = RUNNING;
            end
            RUNNING: begin
                go_pending_d = 1'b0;
            end
            default: state_d = HOLD;
        endcase
    end

    // State, counter, latched strap and boot address registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            bootmode_q   <= 2'd0;
            go_pending_q <= 1'b0;
            boot_q       <= DefaultBootAddr[AddrWidth-1:0];
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bootmode_q   <= bootmode_d;
            go_pending_q <= go_pending_d;
            boot_q       <= boot_d;
        end
    end

    // Core reset follows the RUNNING state one cycle later, glitch-free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) core_rst_q <= 1'b0;
        else         core_rst_q <= (state_q == RUNNING);
    end

    assign core_rst_no     = core_rst_q;
    assign core_released_o = (state_q == RUNNING);
    assign boot_addr_o     = boot_q;

endmodule

// File: tb/tb_carfield_boot_ctrl.sv
// Self-checking bench for carfield_boot_ctrl (AddrWidth 48, hold 16).
module tb_carfield_boot_ctrl;
    import carfield_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  bootmode = 2'd0;
    logic        valid = 1'b0, write = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        ready, err, core_rst, released;
    logic [31:0] rdata;
    logic [47:0] boot_addr;

    always #5 clk = ~clk;

    carfield_boot_ctrl #(.AddrWidth(48), .RstHoldCycles(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bootmode_i(bootmode),
        .reg_valid_i(valid), .reg_write_i(write), .reg_addr_i(addr),
        .reg_wdata_i(wdata), .reg_wstrb_i(wstrb),
        .reg_ready_o(ready), .reg_rdata_o(rdata), .reg_error_o(err),
        .boot_addr_o(boot_addr), .core_rst_no(core_rst),
        .core_released_o(released)
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nmis = 0;
    int   cyc;

    // Edges seen since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the commit edge.
    task automatic reg_acc(input string tag, input bit wr, input logic [3:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input logic [31:0] exp_rd, input bit exp_err);
        exp_t e;
        valid = 1'b1; write = wr; addr = a; wdata = d; wstrb = s;
        e.tag = tag; e.rdata = exp_rd; e.err = exp_err;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_rdy"}, 64'(ready), 64'(1'b1));
        chk({e.tag, "_rdata"}, 64'(rdata), 64'(e.rdata));
        chk({e.tag, "_err"}, 64'(err), 64'(e.err));
        @(posedge clk);
        #1;
        valid = 1'b0; write = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < n) chk("wait_timeout", 64'(cyc), 64'(n));
    endtask

    task automatic do_reset(input logic [1:0] m);
        rst_n = 1'b0;
        bootmode = m;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_core", 64'(core_rst), 64'(0));
        chk("rst_rel", 64'(released), 64'(0));
        chk("rst_addr", 64'(boot_addr), 64'h100_0000);
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_ready", 64'(ready), 64'(0));

        // Autonomous boot: release exactly after edge 17
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk($sformatf("m0_core_%0d", k), 64'(core_rst), 64'(k >= 17));
            chk($sformatf("m0_rel_%0d", k), 64'(released), 64'(k >= 16));
        end
        chk("m0_addr", 64'(boot_addr), 64'h100_0000);
        reg_acc("m0_status", 0, StatusOffs, 0, 0, 32'h2, 0);

        // Serial link boot: program address in WAIT, then GO
        do_reset(2'd2);
        wait_cyc(16);
        chk("m2_wait_rel", 64'(released), 64'(0));
        reg_acc("m2_st_wait", 0, StatusOffs, 0, 0, 32'h9, 0);
        reg_acc("lo_wr", 1, BootLoOffs, 32'h8000_0000, 4'hF, 0, 0);
        reg_acc("hi_wr", 1, BootHiOffs, 32'hFFFF_FFFF, 4'hF, 0, 0);
        reg_acc("hi_rd", 0, BootHiOffs, 0, 0, 32'h0000_FFFF, 0);
        chk("hi_addr", 64'(boot_addr), 64'hFFFF_8000_0000);
        reg_acc("hi_clr", 1, BootHiOffs, 32'h0, 4'hF, 0, 0);
        reg_acc("lo_strb", 1, BootLoOffs, 32'h1234_5678, 4'b0011, 0, 0);
        reg_acc("lo_strb_rd", 0, BootLoOffs, 0, 0, 32'h8000_5678, 0);
        reg_acc("lo_fix", 1, BootLoOffs, 32'h8000_0000, 4'b0011, 0, 0);
        reg_acc("mis_wr", 1, 4'h2, 32'hDEAD_BEEF, 4'hF, 0, 1);
        reg_acc("mis_rd", 0, 4'h1, 0, 0, 0, 1);
        reg_acc("st_wr", 1, StatusOffs, 32'hFFFF_FFFF, 4'hF, 0, 1);
        reg_acc("lo_keep", 0, BootLoOffs, 0, 0, 32'h8000_0000, 0);
        reg_acc("m2_st_keep", 0, StatusOffs, 0, 0, 32'h9, 0);
        reg_acc("go", 1, CtrlOffs, 32'h1, 4'hF, 0, 0);
        chk("go_rel", 64'(released), 64'(1));
        chk("go_core_t", 64'(core_rst), 64'(0));
        @(negedge clk);
        chk("go_core_t1", 64'(core_rst), 64'(1));
        chk("go_addr", 64'(boot_addr), 64'h8000_0000);
        reg_acc("m2_st_run", 0, StatusOffs, 0, 0, 32'hA, 0);
        reg_acc("ctrl_rd", 0, CtrlOffs, 0, 0, 32'h0, 0);
        reg_acc("hi_run", 1, BootHiOffs, 32'h1234, 4'hF, 0, 1);
        reg_acc("lo_run", 1, BootLoOffs, 32'h1234, 4'hF, 0, 1);
        reg_acc("go_run", 1, CtrlOffs, 32'h1, 4'hF, 0, 0);
        reg_acc("hi_run_rd", 0, BootHiOffs, 0, 0, 32'h0, 0);
        reg_acc("lo_run_rd", 0, BootLoOffs, 0, 0, 32'h8000_0000, 0);
        chk("run_addr", 64'(boot_addr), 64'h8000_0000);

        // Asynchronous reset while running
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_core", 64'(core_rst), 64'(0));
        chk("arst_rel", 64'(released), 64'(0));
        chk("arst_addr", 64'(boot_addr), 64'h100_0000);
        @(negedge clk);

        // JTAG boot with GO written during HOLD
        do_reset(2'd1);
        wait_cyc(2);
        reg_acc("hold_go", 1, CtrlOffs, 32'h1, 4'hF, 0, 0);
        reg_acc("m1_st_hold", 0, StatusOffs, 0, 0, 32'h10, 0);
        wait_cyc(16);
        chk("m1_rel", 64'(released), 64'(1));
        chk("m1_core_t", 64'(core_rst), 64'(0));
        @(negedge clk);
        chk("m1_core_t1", 64'(core_rst), 64'(1));
        reg_acc("m1_st_run", 0, StatusOffs, 0, 0, 32'h6, 0);

        // GO in the very cycle the hold expires
        do_reset(2'd2);
        wait_cyc(15);
        reg_acc("exp_go", 1, CtrlOffs, 32'h1, 4'hF, 0, 0);
        chk("exp_go_rel", 64'(released), 64'(1));
        reg_acc("exp_go_st", 0, StatusOffs, 0, 0, 32'hA, 0);

        // Boot address write on the release edge is still accepted
        do_reset(2'd0);
        wait_cyc(15);
        reg_acc("edge_lo", 1, BootLoOffs, 32'h4000_0000, 4'hF, 0, 0);
        chk("edge_rel", 64'(released), 64'(1));
        chk("edge_addr", 64'(boot_addr), 64'h4000_0000);

        // Reserved mode waits like JTAG
        do_reset(2'd3);
        wait_cyc(16);
        chk("m3_rel", 64'(released), 64'(0));
        reg_acc("m3_st", 0, StatusOffs, 0, 0, 32'hD, 0);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
